uart_beep_seq: RTL
==================

Name: uart_beep_seq

Overview:
- Parametrised multi-channel event annunciator. It succeeds the single-channel UART beep indicator.
- Watches N_CH event lines, typically uart_en strobes from several UART/filter ports, and detects their rising edges.
- Queues detected events and plays a per-channel beep pattern: channel i sounds i+1 beeps.
- Each beep is a gated square-wave tone for the board buzzer. Optional retrigger mode. Sits between the port receivers and the buzzer pin.

Parameters:
- N_CH, 4, number of event channels (1..8).
- CNT_W, 27, width of the duration counter; must hold max(ON_TICKS, OFF_TICKS).
- ON_TICKS, 5000000, clock cycles per beep (>=1).
- OFF_TICKS, 2500000, clock cycles of silence between beeps of one pattern (>=1).
- TONE_HALF, 12500, clock cycles per tone half-period (>=1).
- RETRIG, 0, 1 = a new event on the active channel restarts its pattern.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-low reset.
- uart_en  in  N_CH  asynchronous event levels; a rising edge is an event.
- beep_en  out  1  high while a beep is sounding.
- beep_out  out  1  tone square wave; 0 whenever beep_en=0.
- busy  out  1  high when state != IDLE.
- active_ch  out  CH_W=max(1,clog2(N_CH))  channel being played; 0 in IDLE.
- pending  out  N_CH  queued, unserviced events.

Behaviour:
- Reset (sys_rst=0, asynchronous): all flops clear. beep_en=0, beep_out=0, busy=0, active_ch=0, pending=0, state=IDLE.
- Edge detection, per channel:
  - Two flops: s0<=uart_en[i], s1<=s0. rise[i]=s0&~s1, one cycle wide.
  - An input held high across reset release yields exactly one rise.
- Queue:
  - pending[i] sets on the edge where rise[i]=1.
  - It clears on the edge where the FSM leaves IDLE for channel i.
  - A set and a clear on the same edge leave the bit set. Further rises while a bit is set merge into it.
- FSM states: IDLE, ON, OFF.
  - IDLE: if pending!=0, select the lowest set index c. Load remaining=c+1, active_ch=c, dur=0, tone=0, beep_out=0. Go to ON.
  - ON: beep_en=1; dur counts 0..ON_TICKS-1.
    - At dur=ON_TICKS-1: remaining-- and dur=0.
    - If the remaining count was 1, go to IDLE; otherwise go to OFF.
  - OFF: beep_en=0, beep_out=0; dur counts 0..OFF_TICKS-1, then go to ON with tone=0.
- Tone:
  - In ON, tone counter 0..TONE_HALF-1; beep_out toggles when it wraps. The first half-period of each beep is 0.
  - Forced to 0 outside ON.
- Latency and sequencing:
  - Input sampled high first at edge t0 gives rise during t0..t1 and pending set at t1. From IDLE, state=ON and beep_en=1 after t2.
  - A pattern lasts (c+1)*ON_TICKS + c*OFF_TICKS cycles.
  - Between queued patterns there is exactly one IDLE cycle, with busy=0 for that cycle.
- Priority: simultaneous rises all set their pending bits. They are served in ascending index, and a lower index never preempts a running pattern.
- Retrigger:
  - RETRIG=0: a rise on the active channel sets pending[c], so the pattern replays after completion.
  - RETRIG=1: a rise on the active channel restarts its pattern. state=ON, remaining=c+1, dur=0, tone=0, beep_out=0. pending[c] is not set.
  - Rises on other channels queue normally in both modes.
- Widths: dur is CNT_W bits and never exceeds max(ON_TICKS, OFF_TICKS)-1. remaining is clog2(N_CH+1) bits. No wrap-around is reachable.

Decomposition:
- Package beep_pkg holds:
  - the state encoding: IDLE=2'd0, ON=2'd1, OFF=2'd2;
  - a clog2 function;
  - the CH_W derivation.
- Sub-module uart_beep_edge (parameter N_CH): the two-flop sync and rise detect per channel, same clock and reset. The top level holds the queue, FSM, duration and tone counters.

Test Plan (N_CH=2, ON_TICKS=4, OFF_TICKS=2, TONE_HALF=1, CNT_W=4):
1. Hold sys_rst=0 with random uart_en -> all outputs 0. Release with uart_en=0 -> stays IDLE indefinitely.
2. Pulse uart_en[0] for 3 cycles -> beep_en=1 after edge t2 for exactly 4 cycles. beep_out=0,1,0,1. active_ch=0, busy=1 for 4 cycles, then all 0.
3. Rise on uart_en[1] -> beep_en pattern 1111 00 1111. busy=1 for 10 cycles. active_ch=1, and beep_out=0 during the gap.
4. Simultaneous rises on ch0 and ch1 -> pending=2'b11 and ch0 pattern (4 cycles). Then one IDLE cycle with pending=2'b10, then the ch1 pattern (10 cycles).
5. RETRIG=1: re-rise of ch1 during its OFF gap -> state ON immediately with a 2-beep pattern restarted, pending stays 0. With RETRIG=0, same stimulus -> pending[1]=1 and the pattern replays after one IDLE cycle.
6. Assert sys_rst mid-ON, asynchronously between clock edges -> beep_en, beep_out, busy, pending are 0 before the next edge. After release with inputs low -> no beep.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared definitions for the multi-channel beep annunciator: FSM encoding and
// width helpers used to size channel, counter and tone fields.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int v;
    int result;
    v      = value - 32'sd1;
    result = 32'sd0;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

  // Channel-index width: never narrower than one bit, even for a single channel.
  function automatic int bits_for(input int value);
    return (clog2(value) < 32'sd1) ? 32'sd1 : clog2(value);
  endfunction

endpackage

// File: rtl/uart_beep_edge.sv
// Per-channel two-flop sampler of the asynchronous event levels with a
// one-cycle rising-edge strobe.
module uart_beep_edge #(
  parameter int N_CH = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [N_CH-1:0] uart_en,
  output logic [N_CH-1:0] rise
);

  logic [N_CH-1:0] s0_r;
  logic [N_CH-1:0] s1_r;

  // Sample chain; the second stage gives the previous level for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      s0_r <= '0;
      s1_r <= '0;
    end else begin
      s0_r <= uart_en;
      s1_r <= s0_r;
    end
  end

  assign rise = s0_r & ~s1_r;

endmodule

// File: rtl/uart_beep_seq.sv
// Multi-channel event annunciator: queues rising edges per channel and plays
// channel c as c+1 gated square-wave beeps on the buzzer outputs.
module uart_beep_seq
  import beep_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 27,
  parameter int ON_TICKS  = 5000000,
  parameter int OFF_TICKS = 2500000,
  parameter int TONE_HALF = 12500,
  parameter int RETRIG    = 0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [N_CH-1:0]             uart_en,
  output logic                        beep_en,
  output logic                        beep_out,
  output logic                        busy,
  output logic [bits_for(N_CH)-1:0]   active_ch,
  output logic [N_CH-1:0]             pending
);

  localparam int CH_W   = bits_for(N_CH);
  localparam int REM_W  = clog2(N_CH + 32'sd1);
  localparam int TONE_W = bits_for(TONE_HALF);

  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_TICKS - 32'sd1);
  localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_TICKS - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 32'sd1);
  localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
  localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);
  localparam logic [N_CH-1:0]   CH_ONE    = N_CH'(1);

  state_t            state_r, state_s;
  logic [REM_W-1:0]  rem_r, rem_s;
  logic [CNT_W-1:0]  dur_r, dur_s;
  logic [TONE_W-1:0] tone_r, tone_s;
  logic              beep_out_r, beep_s;
  logic              beep_en_r, busy_r;
  logic [CH_W-1:0]   active_r, active_s, sel_s;
  logic [N_CH-1:0]   pending_r, pending_s;
  logic [N_CH-1:0]   rise_s, set_s, clr_s, act_mask_s;
  logic              retrig_s;

  uart_beep_edge #(.N_CH(N_CH)) u_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .uart_en (uart_en),
    .rise    (rise_s)
  );

  // Lowest pending index wins; a descending scan leaves the smallest set bit.
  always_comb begin
    sel_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sel_s = pending_r[i] ? CH_W'(i) : sel_s;
    end
  end

  assign act_mask_s = CH_ONE << active_r;

  // Next-state, counters, tone and queue update.
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    dur_s    = dur_r;
    tone_s   = '0;
    beep_s   = 1'b0;
    active_s = active_r;
    clr_s    = '0;
    set_s    = rise_s;
    retrig_s = (RETRIG != 32'sd0) && (state_r != IDLE) && ((rise_s & act_mask_s) != '0);
    case (state_r)
      IDLE: begin
        active_s = '0;
        if (pending_r != '0) begin
          state_s  = ON;
          rem_s    = REM_W'(sel_s) + REM_ONE;
          active_s = sel_s;
          dur_s    = '0;
          clr_s    = CH_ONE << sel_s;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (dur_r == ON_LAST) begin
          dur_s = '0;
          rem_s = rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_s  = IDLE;
            active_s = '0;
          end else begin
            state_s = OFF;
          end
        end else begin
          dur_s = dur_r + CNT_ONE;
          if (tone_r == TONE_LAST) begin
            tone_s = '0;
            beep_s = ~beep_out_r;
          end else begin
            tone_s = tone_r + TONE_ONE;
            beep_s = beep_out_r;
          end
        end
      end
      OFF: begin
        if (dur_r == OFF_LAST) begin
          dur_s   = '0;
          state_s = ON;
        end else begin
          dur_s = dur_r + CNT_ONE;
        end
      end
      default: begin
        state_s  = IDLE;
        rem_s    = '0;
        dur_s    = '0;
        active_s = '0;
      end
    endcase
    // A retrigger restarts the running pattern instead of queueing a replay.
    if (retrig_s) begin
      state_s  = ON;
      rem_s    = REM_W'(active_r) + REM_ONE;
      dur_s    = '0;
      tone_s   = '0;
      beep_s   = 1'b0;
      active_s = active_r;
      set_s    = rise_s & ~act_mask_s;
    end else begin
      set_s = rise_s;
    end
    pending_s = (pending_r & ~clr_s) | set_s;
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r    <= IDLE;
      rem_r      <= '0;
      dur_r      <= '0;
      tone_r     <= '0;
      beep_out_r <= 1'b0;
      beep_en_r  <= 1'b0;
      busy_r     <= 1'b0;
      active_r   <= '0;
      pending_r  <= '0;
    end else begin
      state_r    <= state_s;
      rem_r      <= rem_s;
      dur_r      <= dur_s;
      tone_r     <= tone_s;
      beep_out_r <= beep_s;
      beep_en_r  <= (state_s == ON);
      busy_r     <= (state_s != IDLE);
      active_r   <= active_s;
      pending_r  <= pending_s;
    end
  end

  assign beep_en   = beep_en_r;
  assign beep_out  = beep_out_r;
  assign busy      = busy_r;
  assign active_ch = active_r;
  assign pending   = pending_r;

endmodule
